// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: round/enable sequencer for the ASCON-128 permutation datapath
module ascon_ctrl_fsm #(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       sel_o,
  output logic       en_o,
  output logic [3:0] round_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_o,
  output logic       en_xor_key_final_o,
  output logic       en_xor_lsb_o,
  output logic       en_out_cipher_o,
  output logic       en_out_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int AW = NB_AD_BLOCKS > 1 ? $clog2(NB_AD_BLOCKS) : 1;
  localparam int PW = NB_PT_BLOCKS > 1 ? $clog2(NB_PT_BLOCKS) : 1;
  typedef enum logic [2:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] ad_cnt, ad_n;
  logic [PW-1:0] pt_cnt, pt_n;
  logic r11, ad_last, pt_last, pt_next_last, wait_st, xfer;
  assign r11 = cnt == 4'd11;
  assign ad_last = int'(ad_cnt) == NB_AD_BLOCKS - 1;
  assign pt_last = int'(pt_cnt) == NB_PT_BLOCKS - 1;
  assign pt_next_last = int'(pt_cnt) + 2 == NB_PT_BLOCKS;
  assign wait_st = state == WAIT_AD || state == WAIT_PT;
  assign xfer = wait_st && data_valid_i;
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      state <= IDLE;
      cnt <= '0;
      ad_cnt <= '0;
      pt_cnt <= '0;
      cipher_valid_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ad_cnt <= ad_n;
      pt_cnt <= pt_n;
      cipher_valid_o <= en_out_cipher_o;
    end
  // round counter is preloaded on entry to a wait state with the round the transfer will run
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ad_n = ad_cnt;
    pt_n = pt_cnt;
    case (state)
      IDLE: if (start_i) begin
        state_n = INIT;
        cnt_n = '0;
        ad_n = '0;
        pt_n = '0;
      end
      INIT: begin
        state_n = r11 ? WAIT_AD : INIT;
        cnt_n = r11 ? 4'd6 : cnt + 4'd1;
      end
      WAIT_AD: if (data_valid_i) begin
        state_n = AD;
        cnt_n = 4'd7;
      end
      AD: if (!r11) cnt_n = cnt + 4'd1;
        else if (ad_last) begin
          state_n = WAIT_PT;
          cnt_n = pt_last ? 4'd0 : 4'd6;
        end else begin
          state_n = WAIT_AD;
          cnt_n = 4'd6;
          ad_n = ad_cnt + 1'b1;
        end
      WAIT_PT: if (data_valid_i) begin
        state_n = pt_last ? FINAL : PT;
        cnt_n = pt_last ? 4'd1 : 4'd7;
      end
      PT: if (!r11) cnt_n = cnt + 4'd1;
        else begin
          state_n = WAIT_PT;
          cnt_n = pt_next_last ? 4'd0 : 4'd6;
          pt_n = pt_cnt + 1'b1;
        end
      FINAL: begin
        state_n = r11 ? DONE : FINAL;
        cnt_n = r11 ? 4'd0 : cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    data_ready_o = wait_st;
    en_o = xfer || state == INIT || state == AD || state == PT || state == FINAL;
    sel_o = en_o && !(state == INIT && cnt == 4'd0);
    round_o = cnt;
    en_xor_data_o = xfer;
    en_xor_key_o = xfer && state == WAIT_PT && pt_last;
    en_xor_key_final_o = (state == INIT || state == FINAL) && r11;
    en_xor_lsb_o = state == AD && r11 && ad_last;
    en_out_cipher_o = xfer && state == WAIT_PT;
    en_out_tag_o = state == FINAL && r11;
    busy_o = state != IDLE;
    done_o = state == DONE;
  end
endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm: schedule-queue reference model, scenario table and random stimulus
module tb_ascon_ctrl_fsm;
  localparam int NAD = 1, NPT = 4;
  logic clock_i = 1'b0, resetb_i = 1'b0, start_i = 1'b0, data_valid_i = 1'b0;
  logic data_ready_o, sel_o, en_o, en_xor_data_o, en_xor_key_o, en_xor_key_final_o;
  logic en_xor_lsb_o, en_out_cipher_o, en_out_tag_o, cipher_valid_o, busy_o, done_o;
  logic [3:0] round_o;
  ascon_ctrl_fsm #(.NB_AD_BLOCKS(NAD), .NB_PT_BLOCKS(NPT)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .sel_o(sel_o), .en_o(en_o), .round_o(round_o),
    .en_xor_data_o(en_xor_data_o), .en_xor_key_o(en_xor_key_o),
    .en_xor_key_final_o(en_xor_key_final_o), .en_xor_lsb_o(en_xor_lsb_o),
    .en_out_cipher_o(en_out_cipher_o), .en_out_tag_o(en_out_tag_o),
    .cipher_valid_o(cipher_valid_o), .busy_o(busy_o), .done_o(done_o));
  always #5 clock_i = ~clock_i;
  // one queued entry per permutation cycle; nv marks a step that waits for a data block
  typedef struct packed {
    logic nv; logic [3:0] rnd; logic sel, en, xd, xk, kf, lsb, oc, ot, dn;
  } step_t;
  typedef struct {int stall; int pulse; int exp_done;} scen_t;
  step_t q[$];
  logic prev_oc = 1'b0;
  int total = 0, bad = 0;
  task automatic push(input logic nv, input int r, input logic xd, xk, kf, lsb, oc, ot);
    step_t s;
    s = '0;
    s.nv = nv; s.rnd = 4'(r); s.sel = nv || r != 0; s.en = 1'b1;
    s.xd = xd; s.xk = xk; s.kf = kf; s.lsb = lsb; s.oc = oc; s.ot = ot;
    q.push_back(s);
  endtask
  task automatic load();
    step_t s;
    q.delete();
    for (int r = 0; r < 12; r++) push(0, r, 0, 0, r == 11, 0, 0, 0);
    for (int a = 0; a < NAD; a++) begin
      push(1, 6, 1, 0, 0, 0, 0, 0);
      for (int r = 7; r < 12; r++) push(0, r, 0, 0, 0, r == 11 && a == NAD - 1, 0, 0);
    end
    for (int p = 0; p < NPT - 1; p++) begin
      push(1, 6, 1, 0, 0, 0, 1, 0);
      for (int r = 7; r < 12; r++) push(0, r, 0, 0, 0, 0, 0, 0);
    end
    push(1, 0, 1, 1, 0, 0, 1, 0);
    for (int r = 1; r < 12; r++) push(0, r, 0, 0, r == 11, 0, 0, r == 11);
    s = '0;
    s.dn = 1'b1;
    q.push_back(s);
  endtask
  function automatic logic [15:0] expv(input logic v);
    step_t h;
    logic go;
    if (q.size() == 0) return {12'h000, prev_oc, 3'b000};
    h = q[0];
    go = !h.nv || v;
    return {h.nv, go & h.sel, go & h.en, h.rnd, go & h.xd, go & h.xk, go & h.kf,
            go & h.lsb, go & h.oc, go & h.ot, prev_oc, 1'b1, h.dn};
  endfunction
  task automatic advance(input logic st, input logic v);
    step_t h;
    if (q.size() == 0) begin
      prev_oc = 1'b0;
      if (st) load();
    end else begin
      h = q[0];
      prev_oc = (!h.nv || v) & h.oc;
      if (!h.nv || v) void'(q.pop_front());
    end
  endtask
  function automatic logic [15:0] actv();
    return {data_ready_o, sel_o, en_o, round_o, en_xor_data_o, en_xor_key_o, en_xor_key_final_o,
            en_xor_lsb_o, en_out_cipher_o, en_out_tag_o, cipher_valid_o, busy_o, done_o};
  endfunction
  task automatic check(input string nm, input int c, input logic [15:0] e);
    logic [15:0] a;
    a = actv();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, a, e);
    end
  endtask
  task automatic cyc(input logic st, input logic v, input string nm, input int c, output logic dn);
    @(negedge clock_i);
    start_i = st;
    data_valid_i = v;
    #1;
    check(nm, c, expv(v));
    dn = done_o;
    advance(st, v);
  endtask
  task automatic hard_reset();
    resetb_i = 1'b0;
    q.delete();
    prev_oc = 1'b0;
  endtask
  initial begin
    scen_t tbl[5];
    logic dn;
    int done_at;
    tbl[0] = '{0, -1, 49};
    tbl[1] = '{7, -1, 56};
    tbl[2] = '{0, 15, 49};
    tbl[3] = '{0, 40, 49};
    tbl[4] = '{3, 40, 52};
    hard_reset();
    repeat (2) @(negedge clock_i);
    #1;
    check("reset", -1, 16'h0000);
    resetb_i = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 0, "idle", i, dn);
    foreach (tbl[k]) begin
      done_at = -1;
      for (int i = 0; i < 70; i++) begin
        cyc(i == 0 || i == tbl[k].pulse, !(i >= 19 && i < 19 + tbl[k].stall), "sched", i, dn);
        if (dn && done_at < 0) done_at = i;
      end
      total++;
      if (done_at != tbl[k].exp_done) begin
        bad++;
        $display("FAIL done_cycle scen=%0d got=%0d exp=%0d", k, done_at, tbl[k].exp_done);
      end
    end
    for (int i = 0; i < 42; i++) cyc(i == 0, 1, "pre_abort", i, dn);
    @(negedge clock_i);
    #1;
    hard_reset();
    #1;
    check("abort_async", 42, 16'h0000);
    @(negedge clock_i);
    resetb_i = 1'b1;
    done_at = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(i == 0, 1, "rerun", i, dn);
      if (dn && done_at < 0) done_at = i;
    end
    total++;
    if (done_at != 49) begin
      bad++;
      $display("FAIL rerun_done got=%0d exp=49", done_at);
    end
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, "random", i, dn);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
